mux4_rr_sched: RTL and testbench

//  Round-robin scheduler sharing one mux4 4-to-1 select path among four requesters.

---
 rtl/mux4_rr_sched_pkg.sv | 20 ++
 rtl/mux4.sv | 20 ++
 rtl/rr_pick4.sv | 32 +++
 rtl/mux4_rr_sched.sv | 110 +++++++++++
 tb/tb_mux4_rr_sched.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/mux4_rr_sched_pkg.sv
// Shared definitions for the round-robin scheduler: state encoding, widths and
// a one-hot helper used when turning a winner index into a grant vector.
package mux4_rr_sched_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int CNT_W = 8;
    localparam int NREQ  = 4;

    function automatic logic [NREQ-1:0] onehot(input logic [1:0] idx);
        logic [NREQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mux4.sv
// Gate-level 4-to-1 multiplexer: y = c[{s1,s0}].
module mux4 (
    input  logic [3:0] c,
    input  logic       s0,
    input  logic       s1,
    output logic       y
);

    logic s0_n, s1_n;
    logic t0, t1, t2, t3;

    not g_n0 (s0_n, s0);
    not g_n1 (s1_n, s1);
    and g_a0 (t0, c[0], s1_n, s0_n);
    and g_a1 (t1, c[1], s1_n, s0);
    and g_a2 (t2, c[2], s1,   s0_n);
    and g_a3 (t3, c[3], s1,   s0);
    or  g_o  (y, t0, t1, t2, t3);

endmodule

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// scanning upward modulo 4.
module rr_pick4
    import mux4_rr_sched_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [1:0]      ptr,
    output logic [1:0]      win,
    output logic            any
);

    // rot[k] is the request k places above ptr, so rot[0] has top priority.
    logic [NREQ-1:0] rot;
    logic [1:0]      off;

    genvar gi;
    for (gi = 0; gi < NREQ; gi++) begin : g_rot
        assign rot[gi] = req[ptr + 2'(gi)];
    end

    always_comb begin
        off = 2'd0;
        if (rot[0])      off = 2'd0;
        else if (rot[1]) off = 2'd1;
        else if (rot[2]) off = 2'd2;
        else if (rot[3]) off = 2'd3;
    end

    assign win = ptr + off;
    assign any = |req;

endmodule

// File: rtl/mux4_rr_sched.sv
// Round-robin scheduler sharing one mux4 select path among four requesters,
// with bounded tenures and a registered data output.
module mux4_rr_sched
    import mux4_rr_sched_pkg::*;
#(
    parameter int MAX_BEATS = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] c,
    output logic [NREQ-1:0] grant,
    output logic            s0,
    output logic            s1,
    output logic            out,
    output logic            out_valid,
    output logic [1:0]      out_src
);

    state_t           state_reg;
    logic [1:0]       ptr_reg;
    logic [1:0]       sel_reg;
    logic [CNT_W-1:0] beat_cnt_reg;
    logic [NREQ-1:0]  grant_reg;
    logic             out_reg;
    logic             out_valid_reg;
    logic [1:0]       out_src_reg;

    logic [1:0] search_ptr;
    logic [1:0] win;
    logic       any;
    logic       mux_y;
    logic       release_now;
    logic       start_ok;

    // While busy the only search that matters is the one on release, which
    // starts just above the current owner; the same picker serves both paths.
    assign search_ptr = (state_reg == BUSY) ? sel_reg + 2'd1 : ptr_reg;

    rr_pick4 u_pick (
        .req (req),
        .ptr (search_ptr),
        .win (win),
        .any (any)
    );

    mux4 u_mux (
        .c  (c),
        .s0 (sel_reg[0]),
        .s1 (sel_reg[1]),
        .y  (mux_y)
    );

    assign release_now = !req[sel_reg] || (beat_cnt_reg == CNT_W'(MAX_BEATS - 1));
    assign start_ok    = en && any;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            ptr_reg       <= 2'd0;
            sel_reg       <= 2'd0;
            beat_cnt_reg  <= '0;
            grant_reg     <= '0;
            out_reg       <= 1'b0;
            out_valid_reg <= 1'b0;
            out_src_reg   <= 2'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    out_valid_reg <= 1'b0;
                    if (start_ok) begin
                        grant_reg    <= onehot(win);
                        sel_reg      <= win;
                        beat_cnt_reg <= '0;
                        state_reg    <= BUSY;
                    end
                end
                BUSY: begin
                    out_reg       <= mux_y;
                    out_src_reg   <= sel_reg;
                    out_valid_reg <= 1'b1;
                    if (release_now) begin
                        ptr_reg <= sel_reg + 2'd1;
                        // An expired owner still requesting sits last in this search.
                        if (start_ok) begin
                            grant_reg    <= onehot(win);
                            sel_reg      <= win;
                            beat_cnt_reg <= '0;
                        end else begin
                            grant_reg <= '0;
                            state_reg <= IDLE;
                        end
                    end else begin
                        beat_cnt_reg <= beat_cnt_reg + CNT_W'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign grant     = grant_reg;
    assign s0        = sel_reg[0];
    assign s1        = sel_reg[1];
    assign out       = out_reg;
    assign out_valid = out_valid_reg;
    assign out_src   = out_src_reg;

endmodule

// File: tb/tb_mux4_rr_sched.sv
// Randomized and directed bench for mux4_rr_sched with a queue-based scoreboard
// fed by a tenure-level reference model.
module tb_mux4_rr_sched;

    localparam int MB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic [3:0] req = 4'd0;
    logic [3:0] c   = 4'd0;
    logic [3:0] grant;
    logic       s0, s1, out, out_valid;
    logic [1:0] out_src;

    mux4_rr_sched #(.MAX_BEATS(MB)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req       (req),
        .c         (c),
        .grant     (grant),
        .s0        (s0),
        .s1        (s1),
        .out       (out),
        .out_valid (out_valid),
        .out_src   (out_src)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] grant;
        logic [1:0] sel;
        logic       ov;
        logic       o;
        logic [1:0] src;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    // Reference model: who owns the path, how many beats it has used, where
    // the next round-robin search starts, and what the output side shows.
    int         m_owner = -1;
    int         m_beats = 0;
    int         m_ptr   = 0;
    logic [1:0] m_sel   = 2'd0;
    logic       m_out   = 1'b0;
    logic       m_ov    = 1'b0;
    logic [1:0] m_src   = 2'd0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic int search(input logic [3:0] r, input int start);
        for (int k = 0; k < 4; k++) begin
            if (r[(start + k) % 4]) return (start + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_step();
        int w;
        exp_t e;
        if (rst) begin
            m_owner = -1; m_beats = 0; m_ptr = 0;
            m_sel = 2'd0; m_out = 1'b0; m_ov = 1'b0; m_src = 2'd0;
        end else if (m_owner >= 0) begin
            m_ov  = 1'b1;
            m_out = c[m_owner];
            m_src = 2'(m_owner);
            if (!req[m_owner] || m_beats == MB) begin
                m_ptr = (m_owner + 1) % 4;
                w = en ? search(req, m_ptr) : -1;
                if (w >= 0) begin
                    m_owner = w; m_beats = 1; m_sel = 2'(w);
                end else begin
                    m_owner = -1;
                end
            end else begin
                m_beats++;
            end
        end else begin
            m_ov = 1'b0;
            w = en ? search(req, m_ptr) : -1;
            if (w >= 0) begin
                m_owner = w; m_beats = 1; m_sel = 2'(w);
            end
        end
        e.grant = (m_owner >= 0) ? 4'(1 << m_owner) : 4'd0;
        e.sel   = m_sel;
        e.ov    = m_ov;
        e.o     = m_out;
        e.src   = m_src;
        exp_q.push_back(e);
    endtask

    // Inputs change between edges; a reset raised here must clear outputs at once.
    task automatic drive(input logic r_rst, input logic r_en, input logic [3:0] r_req, input logic [3:0] r_c);
        @(negedge clk);
        rst = r_rst; en = r_en; req = r_req; c = r_c;
        if (r_rst) begin
            #1;
            chk("async_rst_out", {grant, s1, s0, out, out_valid}, 8'd0);
            chk("async_rst_src", {6'd0, out_src}, 8'd0);
        end
        model_step();
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        cyc++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("grant", {4'd0, grant}, {4'd0, e.grant});
            chk("sel", {6'd0, s1, s0}, {6'd0, e.sel});
            chk("out_valid", {7'd0, out_valid}, {7'd0, e.ov});
            chk("out", {7'd0, out}, {7'd0, e.o});
            if (e.ov) chk("out_src", {6'd0, out_src}, {6'd0, e.src});
            $display("[TB] cyc %0d grant=%b sel=%0d ov=%b out=%b src=%0d", cyc, grant, {s1, s0}, out_valid, out, out_src);
        end
    end

    initial begin
        logic [3:0] r;
        // Reset held with random activity on the inputs.
        repeat (2) drive(1'b1, 1'b1, 4'($urandom), 4'($urandom));
        repeat (2) drive(1'b0, 1'b1, 4'd0, 4'($urandom));
        // Single requester.
        drive(1'b0, 1'b1, 4'b0010, 4'b0010);
        drive(1'b0, 1'b1, 4'b0010, 4'b0010);
        drive(1'b0, 1'b1, 4'b0000, 4'b0010);
        repeat (2) drive(1'b0, 1'b1, 4'd0, 4'd0);
        // Fair rotation with all requesting.
        repeat (20) drive(1'b0, 1'b1, 4'b1111, 4'($urandom));
        repeat (2) drive(1'b0, 1'b1, 4'd0, 4'd0);
        // Owner 2 drops as requester 0 rises.
        repeat (2) drive(1'b0, 1'b1, 4'b0100, 4'b0100);
        repeat (3) drive(1'b0, 1'b1, 4'b0001, 4'b0001);
        repeat (2) drive(1'b0, 1'b1, 4'd0, 4'd0);
        // en dropped mid-tenure.
        drive(1'b0, 1'b1, 4'b0010, 4'($urandom));
        drive(1'b0, 1'b1, 4'b1111, 4'($urandom));
        repeat (6) drive(1'b0, 1'b0, 4'b1111, 4'($urandom));
        repeat (3) drive(1'b0, 1'b1, 4'b1111, 4'($urandom));
        // Reset pulse during a tenure, then a lone high requester.
        drive(1'b1, 1'b1, 4'b1111, 4'($urandom));
        repeat (3) drive(1'b0, 1'b1, 4'b1000, 4'($urandom));
        // Randomized traffic; requests tend to persist.
        r = 4'd0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) r = 4'($urandom);
            drive(($urandom_range(0, 79) == 0), ($urandom_range(0, 9) != 0), r, 4'($urandom));
        end
        repeat (2) @(posedge clk);
        #2;
        chk("drain", 8'(exp_q.size()), 8'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
